// File: rtl/fp_square_seq.sv
// fp_square_seq: iterative FloPoCo single-precision squarer (wE=8, wF=23).
// A single shift-add mantissa multiplier is reused over several cycles,
// followed by one round-to-nearest-even cycle. Valid/ready on both sides,
// at most one operand in flight.
//
// Build option: define FP_SQUARE_RADIX4_EN to retire two multiplier bits per
// cycle (12 MUL cycles instead of 24). Results are bit-identical.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | in_ready=1, waiting for an operand
// MUL   | shift-add mantissa product, LSB of multiplier first
// ROUND | normalise, round to nearest even, range check, load r
// DONE  | out_valid=1, r held until out_ready
module fp_square_seq #(
    parameter int WE   = 8,
    parameter int WF   = 23,
    parameter int BIAS = 127
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WE+WF+2:0]   x,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WE+WF+2:0]   r
);

    localparam int MW = WF + 1;      // mantissa width with hidden bit
    localparam int PW = 2 * MW;      // full product width
    localparam int XW = WE + WF + 3; // FloPoCo word width

`ifdef FP_SQUARE_RADIX4_EN
    localparam logic [4:0] CNT_LAST = 5'(MW / 2 - 1);
`else
    localparam logic [4:0] CNT_LAST = 5'(MW - 1);
`endif

    localparam logic [1:0] EXC_ZERO   = 2'b00;
    localparam logic [1:0] EXC_NORMAL = 2'b01;
    localparam logic [1:0] EXC_INF    = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MUL   = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state, state_nxt;

    logic             sign_q;
    logic [WE-1:0]    exp_q;
    logic [PW-1:0]    acc;
    logic [PW-1:0]    mcand;
    logic [MW-1:0]    mplier;
    logic [4:0]       cnt;
    logic [XW-1:0]    r_q;

    logic             accept;
    logic             mul_done;

    logic signed [9:0] e_base;
    logic signed [9:0] e_norm;
    logic signed [9:0] e_fin;
    logic [WF-1:0]     f_trunc;
    logic [WF-1:0]     f_rnd;
    logic              g_bit;
    logic              s_bit;
    logic              inc;
    logic              f_carry;
    logic              res_sign;
    logic [XW-1:0]     round_res;
    logic [PW-1:0]     acc_step;

    assign accept    = in_valid && (state == IDLE);
    assign mul_done  = (cnt == CNT_LAST);
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign r         = r_q;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; special operands bypass the multiplier.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = (x[XW-1 -: 2] == EXC_NORMAL) ? MUL : DONE;
                end
            end
            MUL: begin
                if (mul_done) begin
                    state_nxt = ROUND;
                end
            end
            ROUND: begin
                state_nxt = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Partial-product sum for one MUL cycle (one or two multiplier bits).
    always_comb begin
        acc_step = acc;
        if (mplier[0]) begin
            acc_step = acc_step + mcand;
        end
`ifdef FP_SQUARE_RADIX4_EN
        if (mplier[1]) begin
            acc_step = acc_step + (mcand << 1);
        end
`endif
    end

    // Normalise, round to nearest even and range-check the finished product.
    always_comb begin
        e_base = $signed({1'b0, exp_q, 1'b0}) - 10'(BIAS);
        if (acc[PW-1]) begin
            e_norm  = e_base + 10'sd1;
            f_trunc = acc[PW-2 -: WF];
            g_bit   = acc[PW-2-WF];
            s_bit   = |acc[PW-3-WF:0];
        end else begin
            e_norm  = e_base;
            f_trunc = acc[PW-3 -: WF];
            g_bit   = acc[PW-3-WF];
            s_bit   = |acc[PW-4-WF:0];
        end
        inc              = g_bit & (s_bit | f_trunc[0]);
        {f_carry, f_rnd} = {1'b0, f_trunc} + {{WF{1'b0}}, inc};
        // A carry out of the fraction leaves an all-zero fraction one binade up.
        e_fin    = e_norm + $signed({9'b0, f_carry});
        // x*x is never negative: s xor s.
        res_sign = sign_q ^ sign_q;
        if (e_fin >= 10'sd255) begin
            round_res = {EXC_INF, {(XW-2){1'b0}}};
        end else if (e_fin <= 10'sd0) begin
            round_res = {EXC_ZERO, {(XW-2){1'b0}}};
        end else begin
            round_res = {EXC_NORMAL, res_sign, e_fin[WE-1:0], f_rnd};
        end
    end

    // Datapath: operand capture, shift-add iteration and result register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign_q <= 1'b0;
            exp_q  <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            r_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        sign_q <= x[WE+WF];
                        exp_q  <= x[WE+WF-1 -: WE];
                        acc    <= '0;
                        cnt    <= '0;
                        mcand  <= {{MW{1'b0}}, 1'b1, x[WF-1:0]};
                        mplier <= {1'b1, x[WF-1:0]};
                        if (x[XW-1 -: 2] != EXC_NORMAL) begin
                            // Zero, inf and NaN square to themselves, sign cleared.
                            r_q <= {x[XW-1 -: 2], {(XW-2){1'b0}}};
                        end
                    end
                end
                MUL: begin
                    acc <= acc_step;
                    cnt <= cnt + 5'd1;
`ifdef FP_SQUARE_RADIX4_EN
                    mcand  <= mcand << 2;
                    mplier <= mplier >> 2;
`else
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
`endif
                end
                ROUND: begin
                    r_q <= round_res;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_square_seq.sv
// Scoreboard bench for fp_square_seq: the driver pushes the reference result
// and expected latency on acceptance, the monitor pops and compares when the
// DUT presents a result.
module tb_fp_square_seq;

`ifdef FP_SQUARE_RADIX4_EN
    localparam int LAT_NORMAL = 14;
`else
    localparam int LAT_NORMAL = 26;
`endif

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [33:0] xin;
    logic        out_valid;
    logic        out_ready;
    logic [33:0] r;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [33:0] exp_q[$];
    int          acc_cyc_q[$];
    int          lat_q[$];

    bit hold_ready = 0;
    bit rand_ready = 0;

    fp_square_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (xin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .r         (r)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: real-number squaring of the significand, then RNE by remainder.
    function automatic logic [33:0] ref_sq(input logic [33:0] v);
        longint unsigned m, p, keep, rem, half;
        int e, sh;
        logic [7:0] e8;
        logic [22:0] frac;
        if (v[33:32] != 2'b01) return {v[33:32], 32'b0};
        m = (64'd1 << 23) + 64'(v[22:0]);
        p = m * m;
        e = 2 * int'(v[30:23]) - 127;
        if (p >= (64'd1 << 47)) begin
            sh = 24;
            e  = e + 1;
        end else begin
            sh = 23;
        end
        keep = p >> sh;
        rem  = p - (keep << sh);
        half = 64'd1 << (sh - 1);
        if (rem > half || (rem == half && keep[0])) keep = keep + 1;
        if (keep == (64'd1 << 24)) begin
            keep = keep >> 1;
            e    = e + 1;
        end
        if (e >= 255) return {2'b10, 32'b0};
        if (e <= 0) return 34'b0;
        e8   = e[7:0];
        frac = keep[22:0];
        return {2'b01, 1'b0, e8, frac};
    endfunction

    task automatic send(input logic [33:0] v);
        int n;
        @(negedge clk);
        xin      = v;
        in_valid = 1;
        n = 0;
        while (!in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("send_timeout", 64'(in_ready), 64'd1);
        end else begin
            exp_q.push_back(ref_sq(v));
            acc_cyc_q.push_back(cyc + 1);
            lat_q.push_back((v[33:32] == 2'b01) ? LAT_NORMAL : 1);
        end
        @(posedge clk);
        #1;
        in_valid = 0;
        xin      = {$urandom, $urandom_range(3, 0)};
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
    endtask

    // Consumer readiness, changed away from the active edge.
    initial begin
        out_ready = 1;
        forever begin
            @(posedge clk);
            #2;
            if (hold_ready) out_ready = 0;
            else if (rand_ready) out_ready = ($urandom_range(3, 0) != 0);
            else out_ready = 1;
        end
    end

    // Monitor.
    bit          seen = 0;
    bit          chk_ir = 0;
    logic [33:0] held_r;
    int          lat;
    always @(negedge clk) begin
        if (!rst_n) begin
            seen   = 0;
            chk_ir = 0;
        end else begin
            if (chk_ir) begin
                check("in_ready_after_handshake", 64'(in_ready), 64'd1);
                chk_ir = 0;
            end
            if (out_valid) begin
                check("in_ready_low_while_valid", 64'(in_ready), 64'd0);
                if (!seen) begin
                    seen   = 1;
                    held_r = r;
                    if (exp_q.size() == 0) begin
                        check("unexpected_output", 64'(exp_q.size()), 64'd1);
                    end else begin
                        check("result", 64'(r), 64'(exp_q[0]));
                        lat = cyc + 1 - acc_cyc_q[0];
                        check("latency", 64'(lat), 64'(lat_q[0]));
                    end
                end else begin
                    check("r_stable", 64'(r), 64'(held_r));
                end
                if (out_ready) begin
                    if (exp_q.size() != 0) begin
                        void'(exp_q.pop_front());
                        void'(acc_cyc_q.pop_front());
                        void'(lat_q.pop_front());
                    end
                    seen   = 0;
                    chk_ir = 1;
                end
            end
        end
    end

    // Watchdog.
    initial begin
        #900000;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    logic [33:0] dir[] = '{
        {2'b01, 1'b0, 8'h7F, 23'h400000},   // 1.5
        {2'b01, 1'b1, 8'h80, 23'h400000},   // -3.0
        {2'b01, 1'b0, 8'h7F, 23'h000001},
        {2'b01, 1'b0, 8'h7F, 23'h7FFFFF},
        {2'b01, 1'b0, 8'hC0, 23'h000000},   // overflow
        {2'b01, 1'b0, 8'h30, 23'h000000},   // underflow
        {2'b11, 1'b0, 8'h12, 23'h000345},   // NaN
        {2'b00, 1'b1, 8'h00, 23'h000000},   // zero
        {2'b10, 1'b1, 8'hFF, 23'h000000},   // -inf
        {2'b01, 1'b0, 8'hBF, 23'h000000},   // e lands on 255
        {2'b01, 1'b0, 8'hBE, 23'h7FFFFF},   // just below overflow
        {2'b01, 1'b0, 8'h40, 23'h000000},   // smallest normal result
        {2'b01, 1'b0, 8'h3F, 23'h000000},   // e lands on -1
        {2'b01, 1'b0, 8'h3F, 23'h7FFFFF}    // e lands on 0
    };

    initial begin
        logic [33:0] v;
        int n;
        rst_n    = 0;
        in_valid = 0;
        xin      = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready", 64'(in_ready), 64'd1);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_r", 64'(r), 64'd0);
        @(negedge clk);
        rst_n = 1;

        foreach (dir[i]) send(dir[i]);
        drain();

        // Stalled consumer for 10 cycles.
        hold_ready = 1;
        send({2'b01, 1'b0, 8'h7F, 23'h400000});
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("stall_out_valid_seen", 64'(out_valid), 64'd1);
        repeat (10) @(negedge clk);
        check("stall_out_valid_held", 64'(out_valid), 64'd1);
        hold_ready = 0;
        send({2'b01, 1'b1, 8'h80, 23'h400000});
        send({2'b11, 1'b0, 8'h00, 23'h0});
        send({2'b01, 1'b0, 8'h85, 23'h123456});
        drain();

        // Reset during MUL.
        send({2'b01, 1'b0, 8'h7F, 23'h400000});
        repeat (10) @(posedge clk);
        #1;
        rst_n = 0;
        #1;
        check("midreset_out_valid", 64'(out_valid), 64'd0);
        check("midreset_in_ready", 64'(in_ready), 64'd1);
        exp_q.delete();
        acc_cyc_q.delete();
        lat_q.delete();
        @(negedge clk);
        rst_n = 1;
        send({2'b01, 1'b0, 8'h80, 23'h000000});   // 2.0 -> 4.0
        drain();
        check("ref_four", 64'(ref_sq({2'b01, 1'b0, 8'h80, 23'h0})), 64'({2'b01, 1'b0, 8'h81, 23'h0}));

        // Random operands with a randomly stalling consumer.
        rand_ready = 1;
        for (int i = 0; i < 150; i++) begin
            v = {$urandom_range(3, 0) == 0 ? 2'($urandom_range(3, 0)) : 2'b01,
                 1'($urandom), 8'($urandom), 23'($urandom)};
            if ($urandom_range(3, 0) == 0) v[30:23] = 8'($urandom_range(196, 186));
            else if ($urandom_range(3, 0) == 0) v[30:23] = 8'($urandom_range(68, 58));
            send(v);
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
